// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared defaults and types for the prefetching fetch stage.
//   XLEN_DEF / ILEN_DEF : default address and instruction widths
//   INSTR_BYTES         : PC stride between sequential fetches
//   fetch_entry_t       : one queue slot {pc, instr, filled}
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int XLEN_DEF    = 32;
    localparam int ILEN_DEF    = 32;
    localparam int INSTR_BYTES = 4;

    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [ILEN_DEF-1:0] instr;
        logic                filled;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_entry_queue.sv
// -----------------------------------------------------------------------------
// fetch_entry_queue
// In-order DEPTH-entry store of fetched instructions. An entry is allocated
// (pc known, instruction pending) when a memory request is accepted, filled
// when its response returns, and popped by decode once filled.
//
// Ports
//   clk, reset          : clock, asynchronous active-low reset
//   clear               : drop every entry (redirect); wins over alloc/fill/pop
//   alloc, alloc_pc     : allocate tail entry for an accepted request
//   fill, fill_instr    : write the oldest unfilled entry
//   pop                 : retire the head entry
//   count               : allocated entries
//   unfilled            : allocated entries still waiting for a response
//   head_valid/pc/instr : head entry contents
// -----------------------------------------------------------------------------
module fetch_entry_queue
    import fetch_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int ILEN  = ILEN_DEF,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    alloc,
    input  logic [XLEN-1:0]         alloc_pc,
    input  logic                    fill,
    input  logic [ILEN-1:0]         fill_instr,
    input  logic                    pop,
    output logic [$clog2(DEPTH):0]  count,
    output logic [$clog2(DEPTH):0]  unfilled,
    output logic                    head_valid,
    output logic [XLEN-1:0]         head_pc,
    output logic [ILEN-1:0]         head_instr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [XLEN-1:0]  pc_mem    [DEPTH];
    logic [ILEN-1:0]  instr_mem [DEPTH];
    logic [DEPTH-1:0] filled;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] fill_ptr;

    // Pointers wrap naturally because DEPTH is a power of two. Alloc, fill
    // and pop never touch the same slot in one cycle: alloc targets a free
    // slot, fill an allocated unfilled one, pop a filled one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head     <= '0;
            tail     <= '0;
            fill_ptr <= '0;
            count    <= '0;
            unfilled <= '0;
            filled   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
        end else if (clear) begin
            head     <= '0;
            tail     <= '0;
            fill_ptr <= '0;
            count    <= '0;
            unfilled <= '0;
            filled   <= '0;
        end else begin
            if (alloc) begin
                pc_mem[tail] <= alloc_pc;
                filled[tail] <= 1'b0;
                tail         <= tail + PTR_W'(1);
            end
            if (fill) begin
                instr_mem[fill_ptr] <= fill_instr;
                filled[fill_ptr]    <= 1'b1;
                fill_ptr            <= fill_ptr + PTR_W'(1);
            end
            // Clearing the filled bit on pop keeps an emptied queue from
            // presenting a stale slot when head catches up with tail.
            if (pop) begin
                filled[head] <= 1'b0;
                head         <= head + PTR_W'(1);
            end
            count    <= count + CNT_W'(alloc) - CNT_W'(pop);
            unfilled <= unfilled + CNT_W'(alloc) - CNT_W'(fill);
        end
    end

    assign head_valid = filled[head];
    assign head_pc    = pc_mem[head];
    assign head_instr = instr_mem[head];

endmodule

// File: rtl/fetch_prefetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_prefetch_queue
// Fetch stage with a DEPTH-entry in-order prefetch queue between a
// variable-latency instruction memory and decode. Redirects squash queued
// and in-flight fetches; in-flight beats are discarded by counting them
// (drop_cnt) instead of tagging the memory interface.
//
// Ports
//   clk, reset                      : clock, asynchronous active-low reset
//   redirect_valid, redirect_pc     : taken branch/jump from execute
//   imem_req_valid/ready/addr       : instruction fetch request
//   imem_rsp_valid, imem_rsp_data   : in-order response beats
//   dec_valid/ready                 : decode handshake
//   dec_instr, dec_pc, dec_pc_plus4 : head instruction and its PCs
//   perf_stall_cycles, perf_dropped,
//   perf_redirects                  : saturating counters, only with
//                                     FETCH_PERF_EN defined
//
// Build option: define FETCH_PERF_EN to add the performance counters.
// -----------------------------------------------------------------------------
module fetch_prefetch_queue
    import fetch_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter int              ILEN     = ILEN_DEF,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [ILEN-1:0] dec_instr,
    output logic [XLEN-1:0] dec_pc,
    output logic [XLEN-1:0] dec_pc_plus4
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_stall_cycles,
    output logic [31:0]     perf_dropped,
    output logic [31:0]     perf_redirects
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [XLEN-1:0]  fetch_pc;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] q_count;
    logic [CNT_W-1:0] q_unfilled;
    logic             head_valid;
    logic [XLEN-1:0]  head_pc;
    logic [ILEN-1:0]  head_instr;
    logic             req_fire;
    logic             rsp_drop;
    logic             rsp_take;
    logic             pop;

    assign imem_req_valid = (q_count < CNT_W'(DEPTH)) & ~redirect_valid & reset;
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid & imem_req_ready;

    // Beats still owed to squashed requests arrive first (in-order memory),
    // so every beat is discarded while drop_cnt is non-zero.
    assign rsp_drop = imem_rsp_valid & (drop_cnt != '0);
    assign rsp_take = imem_rsp_valid & (drop_cnt == '0);

    assign pop = head_valid & dec_ready;

    fetch_entry_queue #(
        .XLEN  (XLEN),
        .ILEN  (ILEN),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .clear      (redirect_valid),
        .alloc      (req_fire),
        .alloc_pc   (fetch_pc),
        .fill       (rsp_take),
        .fill_instr (imem_rsp_data),
        .pop        (pop),
        .count      (q_count),
        .unfilled   (q_unfilled),
        .head_valid (head_valid),
        .head_pc    (head_pc),
        .head_instr (head_instr)
    );

    // On redirect, every request still outstanding after this cycle's beat
    // becomes a beat to discard: the unfilled entries plus the existing debt,
    // less whichever kind of beat lands in the redirect cycle itself.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
            drop_cnt <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            drop_cnt <= q_unfilled - CNT_W'(rsp_take) + drop_cnt - CNT_W'(rsp_drop);
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + XLEN'(INSTR_BYTES);
            end
            if (rsp_drop) begin
                drop_cnt <= drop_cnt - CNT_W'(1);
            end
        end
    end

    // Data outputs read only registered queue storage; they are held at zero
    // whenever the head slot holds nothing decodable.
    assign dec_valid    = head_valid;
    assign dec_instr    = head_valid ? head_instr : '0;
    assign dec_pc       = head_valid ? head_pc : '0;
    assign dec_pc_plus4 = head_valid ? head_pc + XLEN'(INSTR_BYTES) : '0;

    a_rsp_has_target: assert property (
        @(posedge clk) disable iff (!reset)
        (imem_rsp_valid && drop_cnt == '0) |-> (q_unfilled != '0)
    );

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_stall_cycles <= '0;
            perf_dropped      <= '0;
            perf_redirects    <= '0;
        end else begin
            if (dec_ready && !dec_valid && perf_stall_cycles != '1) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
            if (rsp_drop && perf_dropped != '1) begin
                perf_dropped <= perf_dropped + 32'd1;
            end
            if (redirect_valid && perf_redirects != '1) begin
                perf_redirects <= perf_redirects + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_prefetch_queue
// Directed plus randomised bench for fetch_prefetch_queue. A memory model
// returns in-order beats with a programmable latency; a scoreboard of
// expected {pc, instr, filled} entries is pushed on every accepted request
// and popped whenever decode takes an instruction.
// -----------------------------------------------------------------------------
module tb_fetch_prefetch_queue;
    import fetch_pkg::*;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } pend_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic [31:0] dec_pc_plus4;

    fetch_prefetch_queue #(
        .XLEN     (32),
        .ILEN     (32),
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
        .dec_pc_plus4   (dec_pc_plus4)
    );

    always #5 clk = ~clk;

    int           n_assert = 0;
    int           n_fail   = 0;
    int           cyc      = 0;
    int           cyc_rel  = 0;
    int           lat      = 1;
    bit           mrdy     = 1'b1;
    bit           drdy     = 1'b1;
    bit           redir    = 1'b0;
    logic [31:0]  redir_pc = '0;
    logic [31:0]  model_pc = '0;
    pend_t        pend[$];
    fetch_entry_t exp_q[$];

    int           fires     = 0;
    int           first_dec = -1;
    bit           after_redir = 1'b0;
    logic [31:0]  first_pc_after = '0;
    bit           wrap_seen = 1'b0;
    logic [31:0]  wrap_plus4 = '1;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Called at a falling edge: drives one cycle of inputs, checks outputs,
    // advances the model for the coming rising edge, then waits a cycle.
    task automatic step();
        pend_t p;
        bit    rsp_now;
        bit    rsp_stale;
        bit    exp_dvalid;
        bit    fire_now;
        bit    pop_now;
        bit    found;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        rsp_stale      = 1'b0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            p = pend.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instr_of(p.addr);
            rsp_stale      = p.stale;
        end
        rsp_now        = imem_rsp_valid;
        redirect_valid = redir;
        redirect_pc    = redir_pc;
        dec_ready      = drdy;
        imem_req_ready = mrdy;
        #1;
        exp_dvalid = (exp_q.size() > 0) && exp_q[0].filled;
        check("dec_valid", {31'd0, dec_valid}, {31'd0, exp_dvalid});
        if (exp_dvalid) begin
            check("dec_pc", dec_pc, exp_q[0].pc);
            check("dec_instr", dec_instr, exp_q[0].instr);
            check("dec_pc_plus4", dec_pc_plus4, exp_q[0].pc + 32'd4);
        end
        check("req_valid", {31'd0, imem_req_valid},
              {31'd0, (exp_q.size() < DEPTH) && !redir});
        fire_now = imem_req_valid && imem_req_ready;
        if (fire_now) check("req_addr", imem_req_addr, model_pc);
        if (dec_valid === 1'b1 && first_dec < 0) first_dec = cyc_rel;
        pop_now = exp_dvalid && drdy && !redir;
        if (pop_now && after_redir) begin
            first_pc_after = dec_pc;
            after_redir    = 1'b0;
        end
        if (pop_now && exp_q[0].pc == 32'hFFFF_FFFC) begin
            wrap_seen  = 1'b1;
            wrap_plus4 = dec_pc_plus4;
        end
        if (rsp_now && !rsp_stale && !redir) begin
            found = 1'b0;
            foreach (exp_q[i]) begin
                if (!found && !exp_q[i].filled) begin
                    exp_q[i].filled = 1'b1;
                    found = 1'b1;
                end
            end
            check("rsp_target", {31'd0, found}, 32'd1);
        end
        if (pop_now) void'(exp_q.pop_front());
        if (fire_now) begin
            fetch_entry_t e;
            e.pc     = model_pc;
            e.instr  = instr_of(model_pc);
            e.filled = 1'b0;
            exp_q.push_back(e);
            p.addr  = imem_req_addr;
            p.due   = cyc + lat;
            p.stale = 1'b0;
            pend.push_back(p);
            model_pc = model_pc + 32'd4;
            fires++;
        end
        if (redir) begin
            foreach (pend[i]) pend[i].stale = 1'b1;
            exp_q.delete();
            model_pc    = redir_pc;
            after_redir = 1'b1;
        end
        redir = 1'b0;
        @(negedge clk);
        cyc++;
        cyc_rel++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Asserted at a falling edge; the memory side is reset with the DUT.
    task automatic do_reset();
        reset          = 1'b0;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        redir          = 1'b0;
        #1;
        check("rst_dec_valid", {31'd0, dec_valid}, 32'd0);
        check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("rst_dec_pc", dec_pc, 32'd0);
        check("rst_dec_instr", dec_instr, 32'd0);
        check("rst_dec_pc_plus4", dec_pc_plus4, 32'd0);
        check("rst_req_addr", imem_req_addr, 32'd0);
        pend.delete();
        exp_q.delete();
        model_pc  = 32'd0;
        cyc_rel   = 0;
        first_dec = -1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        dec_ready      = 1'b0;
        @(negedge clk);

        // streaming, latency 1
        do_reset();
        lat = 1; mrdy = 1'b1; drdy = 1'b1;
        run(12);
        check("first_dec_cycle", first_dec, 32'd2);

        // decode stall fills the queue, then drains in order
        do_reset();
        drdy = 1'b0; fires = 0;
        run(10);
        check("stall_fires", fires, 32'd4);
        drdy = 1'b1;
        run(10);

        // redirect with three beats in flight (response + pop in same cycle)
        do_reset();
        lat = 3;
        run(6);
        redir = 1'b1; redir_pc = 32'h100;
        step();
        run(15);
        check("redir_first_pc", first_pc_after, 32'h100);

        // two redirects one cycle apart
        run(3);
        redir = 1'b1; redir_pc = 32'h200;
        step();
        step();
        redir = 1'b1; redir_pc = 32'h300;
        step();
        run(15);
        check("redir2_first_pc", first_pc_after, 32'h300);

        // back-to-back redirects in consecutive cycles
        redir = 1'b1; redir_pc = 32'h400;
        step();
        redir = 1'b1; redir_pc = 32'h500;
        step();
        run(12);
        check("redir3_first_pc", first_pc_after, 32'h500);

        // address wrap
        lat = 1;
        redir = 1'b1; redir_pc = 32'hFFFF_FFF8;
        step();
        run(10);
        check("wrap_seen", {31'd0, wrap_seen}, 32'd1);
        check("wrap_plus4", wrap_plus4, 32'd0);

        // randomised latency, backpressure and redirects
        for (int i = 0; i < 200; i++) begin
            lat  = $urandom_range(1, 4);
            mrdy = ($urandom_range(0, 3) != 0);
            drdy = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) begin
                redir    = 1'b1;
                redir_pc = 32'h1000 + ($urandom_range(0, 63) << 2);
            end
            step();
        end

        // reset mid-burst, then restart from RESET_PC
        lat = 2; mrdy = 1'b1; drdy = 1'b1;
        run(5);
        do_reset();
        run(12);
        check("post_reset_first_dec", first_dec, 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
